// File: rtl/ifu_pkg.sv
// Shared types for the instruction fetch unit: FSM states, PC step and the buffered fetch entry.
package ifu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } ifu_state_e;

    localparam logic [31:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] word_index(input logic [31:0] pc);
        return pc >> 2;
    endfunction

    function automatic logic [31:0] pc_align(input logic [31:0] pc);
        return pc & ~32'd3;
    endfunction

endpackage

// File: rtl/ifu_if.sv
// Instruction-memory read port plus decode valid/ready port, as seen from the fetch unit (master).
interface ifu_if;

    logic [31:0] Imem_Addr;
    logic        Imem_Rd_En;
    logic [31:0] Imem_Data;
    logic        Inst_Valid;
    logic        Inst_Ready;
    logic [31:0] Inst_Data;
    logic [31:0] Inst_PC;

    modport master (
        output Imem_Addr, Imem_Rd_En, Inst_Valid, Inst_Data, Inst_PC,
        input  Imem_Data, Inst_Ready
    );

    modport slave (
        input  Imem_Addr, Imem_Rd_En, Inst_Valid, Inst_Data, Inst_PC,
        output Imem_Data, Inst_Ready
    );

endinterface

// File: rtl/ifu_fifo.sv
// Fetch buffer: DEPTH x {pc, instr}, head visible combinationally, flush clears in one cycle.
// Push and pop may coincide when full; the head holds its last popped value while empty.
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         Flush_i,
    input  logic         Push_i,
    input  fetch_entry_t Push_Dat_i,
    input  logic         Pop_i,
    output fetch_entry_t Head_Dat_o,
    output logic [CW-1:0] Count_o,
    output logic         Empty_o
);

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  last_q;
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          pop_ok;

    assign Empty_o    = (count_q == '0);
    assign Count_o    = count_q;
    assign pop_ok     = Pop_i && !Empty_o;
    assign Head_Dat_o = Empty_o ? last_q : mem_q[rd_ptr_q];

    always_ff @(posedge Clk) begin
        if (Push_i && !Flush_i) begin
            mem_q[wr_ptr_q] <= Push_Dat_i;
        end
    end

    // last_q keeps the most recently consumed entry so outputs hold while empty
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
        end else begin
            if (pop_ok) begin
                last_q <= mem_q[rd_ptr_q];
            end
            if (Flush_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (Push_i) begin
                    wr_ptr_q <= wr_ptr_q + AW'(1);
                end
                if (pop_ok) begin
                    rd_ptr_q <= rd_ptr_q + AW'(1);
                end
                count_q <= count_q + CW'(Push_i) - CW'(pop_ok);
            end
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch unit: owns the PC, reads combinational imem (0-cycle latency, 1 word/cycle) into a FIFO for decode.
// Stalls fetch when the FIFO is full and not popping; IFU_FETCH_COUNT_EN adds the Fetch_Count push counter.
module instruction_fetch_unit
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned MEM_DEPTH  = 32,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Fetch_En,
    input  logic        Redir_En,
    input  logic [31:0] Redir_PC,
    ifu_if.master       Bus,
    output logic        Fetch_Err
`ifdef IFU_FETCH_COUNT_EN
    ,
    output logic [31:0] Fetch_Count
`endif
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    ifu_state_e    state_q;
    logic          fetch_err_q;
    logic [31:0]   pc_q;
    logic [31:0]   pc_d;
    logic [CW-1:0] count;
    logic          empty;
    logic          pop;
    logic          push;
    logic          pc_in_range;
    logic          redir_in_range;
    fetch_entry_t  push_dat;
    fetch_entry_t  head_dat;

    assign pc_in_range    = word_index(pc_q) < 32'(MEM_DEPTH);
    assign redir_in_range = word_index(Redir_PC) < 32'(MEM_DEPTH);

    assign pop  = !empty && Bus.Inst_Ready;
    assign push = (state_q == RUN) && Fetch_En && !Redir_En && pc_in_range &&
                  ((count < CW'(FIFO_DEPTH)) || pop);

    assign push_dat.pc    = pc_q;
    assign push_dat.instr = Bus.Imem_Data;

    always_comb begin
        pc_d = pc_q;
        if (Redir_En) begin
            pc_d = pc_align(Redir_PC);
        end else if (push) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // A redirect in RUN re-arms the range check on the new target next cycle
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q     <= IDLE;
            fetch_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Fetch_En) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (!Fetch_En) begin
                        state_q <= IDLE;
                    end else if (!Redir_En && !pc_in_range) begin
                        state_q     <= ERR;
                        fetch_err_q <= 1'b1;
                    end
                end
                ERR: begin
                    if (Redir_En && redir_in_range) begin
                        state_q     <= RUN;
                        fetch_err_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    fetch_err_q <= 1'b0;
                end
            endcase
        end
    end

    ifu_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .Clk        (Clk),
        .Rst        (Rst),
        .Flush_i    (Redir_En),
        .Push_i     (push),
        .Push_Dat_i (push_dat),
        .Pop_i      (pop),
        .Head_Dat_o (head_dat),
        .Count_o    (count),
        .Empty_o    (empty)
    );

    assign Bus.Imem_Addr  = word_index(pc_q);
    assign Bus.Imem_Rd_En = push;
    assign Bus.Inst_Valid = !empty;
    assign Bus.Inst_Data  = head_dat.instr;
    assign Bus.Inst_PC    = head_dat.pc;
    assign Fetch_Err      = fetch_err_q;

`ifdef IFU_FETCH_COUNT_EN
    logic [31:0] fetch_cnt_q;

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            fetch_cnt_q <= '0;
        end else if (push) begin
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
        end
    end

    assign Fetch_Count = fetch_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a 32-word combinational memory holding mem[i] = i + 100.
module tb_instruction_fetch_unit;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Fetch_En;
    logic        Redir_En;
    logic [31:0] Redir_PC;
    logic        Fetch_Err;
`ifdef IFU_FETCH_COUNT_EN
    logic [31:0] Fetch_Count;
`endif

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [32];

    ifu_if bus ();

    always #5 Clk = ~Clk;

    assign bus.Imem_Data = (bus.Imem_Addr < 32'd32) ? mem[bus.Imem_Addr[4:0]] : 32'hDEAD_BEEF;

    instruction_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .MEM_DEPTH  (32),
        .FIFO_DEPTH (2)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Fetch_En  (Fetch_En),
        .Redir_En  (Redir_En),
        .Redir_PC  (Redir_PC),
        .Bus       (bus),
        .Fetch_Err (Fetch_Err)
`ifdef IFU_FETCH_COUNT_EN
        ,
        .Fetch_Count (Fetch_Count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'(i + 100);

        // reset state
        Rst = 1'b0; Fetch_En = 1'b0; Redir_En = 1'b0; Redir_PC = '0; bus.Inst_Ready = 1'b0;
        step();
        chk("rst_valid", 32'(bus.Inst_Valid), 32'd0);
        chk("rst_rd_en", 32'(bus.Imem_Rd_En), 32'd0);
        chk("rst_err",   32'(Fetch_Err), 32'd0);
        chk("rst_data",  bus.Inst_Data, 32'd0);
        chk("rst_pc",    bus.Inst_PC, 32'd0);
        chk("rst_addr",  bus.Imem_Addr, 32'd0);

        // streaming at one word per cycle
        Rst = 1'b1; Fetch_En = 1'b1; bus.Inst_Ready = 1'b1; #1;
        chk("idle_rd_en", 32'(bus.Imem_Rd_En), 32'd0);
        step();
        chk("run_rd_en", 32'(bus.Imem_Rd_En), 32'd1);
        chk("run_addr",  bus.Imem_Addr, 32'd0);
        chk("run_valid", 32'(bus.Inst_Valid), 32'd0);
        step();
        for (int k = 0; k < 6; k++) begin
            chk("stream_valid", 32'(bus.Inst_Valid), 32'd1);
            chk("stream_pc",    bus.Inst_PC, 32'(4 * k));
            chk("stream_data",  bus.Inst_Data, 32'(100 + k));
            step();
        end

        // restart at 0 with decode stalled: buffer fills to 2, PC stops at 8
        Redir_En = 1'b1; Redir_PC = 32'h0; bus.Inst_Ready = 1'b0; #1;
        chk("redir_rd_en", 32'(bus.Imem_Rd_En), 32'd0);
        step();
        Redir_En = 1'b0; #1;
        chk("redir1_valid", 32'(bus.Inst_Valid), 32'd0);
        chk("redir1_rd_en", 32'(bus.Imem_Rd_En), 32'd1);
        step();
        chk("stall_first_pc", bus.Inst_PC, 32'd0);
        step();
        for (int k = 0; k < 5; k++) begin
            chk("stall_rd_en", 32'(bus.Imem_Rd_En), 32'd0);
            chk("stall_addr",  bus.Imem_Addr, 32'd2);
            chk("stall_valid", 32'(bus.Inst_Valid), 32'd1);
            chk("stall_pc",    bus.Inst_PC, 32'd0);
            chk("stall_data",  bus.Inst_Data, 32'd100);
            step();
        end
        bus.Inst_Ready = 1'b1; #1;
        chk("full_pop_rd_en", 32'(bus.Imem_Rd_En), 32'd1);
        for (int k = 0; k < 4; k++) begin
            chk("release_pc",   bus.Inst_PC, 32'(4 * k));
            chk("release_data", bus.Inst_Data, 32'(100 + k));
            step();
        end

        // redirect while full, unaligned target
        Redir_En = 1'b1; Redir_PC = 32'h0000_0043; #1;
        chk("redir_full_rd_en", 32'(bus.Imem_Rd_En), 32'd0);
        chk("redir_full_head",  bus.Inst_PC, 32'd16);
        step();
        Redir_En = 1'b0; #1;
        chk("flush_valid",    32'(bus.Inst_Valid), 32'd0);
        chk("flush_addr",     bus.Imem_Addr, 32'h10);
        chk("flush_hold_pc",  bus.Inst_PC, 32'd16);
        chk("flush_hold_dat", bus.Inst_Data, 32'd104);
        step();

        // run to the end of memory
        for (int k = 0; k < 16; k++) begin
            chk("tail_valid", 32'(bus.Inst_Valid), 32'd1);
            chk("tail_pc",    bus.Inst_PC, 32'(32'h40 + 4 * k));
            chk("tail_data",  bus.Inst_Data, 32'(116 + k));
            chk("tail_err",   32'(Fetch_Err), 32'd0);
            step();
        end
        chk("err_set",    32'(Fetch_Err), 32'd1);
        chk("err_valid",  32'(bus.Inst_Valid), 32'd0);
        chk("err_rd_en",  32'(bus.Imem_Rd_En), 32'd0);
        chk("err_hold_pc", bus.Inst_PC, 32'h7C);
        step();
        chk("err_sticky", 32'(Fetch_Err), 32'd1);
        Redir_En = 1'b1; Redir_PC = 32'h80;
        step();
        Redir_En = 1'b0; #1;
        chk("err_redir_oor", 32'(Fetch_Err), 32'd1);
        Redir_En = 1'b1; Redir_PC = 32'h0;
        step();
        Redir_En = 1'b0; #1;
        chk("err_clear", 32'(Fetch_Err), 32'd0);
        chk("err_resume_rd_en", 32'(bus.Imem_Rd_En), 32'd1);
        chk("err_resume_addr",  bus.Imem_Addr, 32'd0);
        step();
        chk("resume_pc0",   bus.Inst_PC, 32'd0);
        chk("resume_data0", bus.Inst_Data, 32'd100);
        step();
        chk("resume_pc1",   bus.Inst_PC, 32'd4);
        chk("resume_data1", bus.Inst_Data, 32'd101);

        // Fetch_En low: no reads, PC held
        Fetch_En = 1'b0; #1;
        chk("hold_rd_en", 32'(bus.Imem_Rd_En), 32'd0);
        step();
        chk("hold_valid", 32'(bus.Inst_Valid), 32'd0);
        chk("hold_addr",  bus.Imem_Addr, 32'd2);
        Fetch_En = 1'b1;
        step();
        step();
        chk("hold_resume_pc",   bus.Inst_PC, 32'd8);
        chk("hold_resume_data", bus.Inst_Data, 32'd102);

        // reset with the buffer full
        bus.Inst_Ready = 1'b0;
        step();
        chk("prerst_rd_en", 32'(bus.Imem_Rd_En), 32'd0);
        chk("prerst_pc",    bus.Inst_PC, 32'd8);
        Rst = 1'b0;
        step();
        chk("midrst_valid", 32'(bus.Inst_Valid), 32'd0);
        chk("midrst_addr",  bus.Imem_Addr, 32'd0);
        chk("midrst_pc",    bus.Inst_PC, 32'd0);
        chk("midrst_err",   32'(Fetch_Err), 32'd0);
        Rst = 1'b1; bus.Inst_Ready = 1'b1;
        step();
        step();
        chk("postrst_pc",   bus.Inst_PC, 32'd0);
        chk("postrst_data", bus.Inst_Data, 32'd100);

`ifdef IFU_FETCH_COUNT_EN
        chk("cnt_1", Fetch_Count, 32'd1);
        for (int k = 0; k < 9; k++) step();
        chk("cnt_10", Fetch_Count, 32'd10);
        Redir_En = 1'b1; Redir_PC = 32'h20;
        step();
        Redir_En = 1'b0; #1;
        chk("cnt_redir", Fetch_Count, 32'd10);
        step();
        chk("cnt_11",       Fetch_Count, 32'd11);
        chk("cnt_redir_pc", bus.Inst_PC, 32'h20);
        chk("cnt_redir_dat", bus.Inst_Data, 32'd108);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
